// File: rtl/ssd1306_pkg.sv
// Shared definitions for the SSD1306 SPI path: shifter state encoding
// (also used by the init sequencer), D/C levels and the byte width.
package ssd1306_pkg;

    localparam int BYTE_W = 8;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        HOLD = 2'd3
    } spi_state_t;

endpackage

// File: rtl/ssd1306_spi_shifter.sv
// SSD1306 4-wire SPI byte serializer, mode 0, MSB first.
// One byte per valid/ready handshake: a byte is accepted at a rising clk_in
// edge where byte_start=1 and byte_ready=1; byte_in and dc_in are captured at
// that edge. byte_start while busy is dropped, never queued.
// All panel-facing outputs are registered so the SPI lines never glitch.
// Optional build macro SSD1306_SPI_BACK2BACK_EN: also accept in the final HOLD
// cycle so consecutive bytes share one chip-select window.
module ssd1306_spi_shifter
    import ssd1306_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic              clk_in,
    input  logic              resetn,
    input  logic              byte_start,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              dc_in,
    output logic              byte_ready,
    output logic              busy,
    output logic              oled_sclk,
    output logic              oled_sdin,
    output logic              oled_csn,
    output logic              oled_dc
);

    // Terminal count of each SCLK half-period; div_cnt never passes it.
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    spi_state_t        state_q, state_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        div_cnt_q, div_cnt_d;
    logic              dc_q, dc_d;
    logic              sclk_q, sclk_d;
    logic              sdin_q, sdin_d;
    logic              csn_q, csn_d;

    logic phase_done;
    logic accept;

    assign phase_done = (div_cnt_q == DIV_LAST);

`ifdef SSD1306_SPI_BACK2BACK_EN
    // Ready while idle and in the last HOLD cycle, so the next byte chains
    // straight into LOW with chip select still asserted.
    assign byte_ready = (state_q == IDLE) || ((state_q == HOLD) && phase_done);
`else
    // Ready only while idle: chip select always deasserts between bytes.
    assign byte_ready = (state_q == IDLE);
`endif

    assign busy   = ~byte_ready;
    assign accept = byte_start && byte_ready;

    // Next-state, divider, bit counter and registered SPI line values.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        dc_d      = dc_q;

        case (state_q)
            IDLE: begin
                div_cnt_d = 8'd0;
            end
            LOW: begin
                if (phase_done) begin
                    state_d   = HIGH;
                    div_cnt_d = 8'd0;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            HIGH: begin
                if (phase_done) begin
                    div_cnt_d = 8'd0;
                    if (bit_cnt_q == 3'd0) begin
                        state_d = HOLD;
                    end else begin
                        // SDIN only moves here, on the falling SCLK edge.
                        shift_d   = {shift_q[BYTE_W-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        state_d   = LOW;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            HOLD: begin
                if (phase_done) begin
                    state_d   = IDLE;
                    div_cnt_d = 8'd0;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                div_cnt_d = 8'd0;
            end
        endcase

        // Accept overrides whatever the phase logic decided.
        if (accept) begin
            shift_d   = byte_in;
            dc_d      = dc_in;
            bit_cnt_d = 3'd7;
            div_cnt_d = 8'd0;
            state_d   = LOW;
        end

        sclk_d = (state_d == HIGH);
        csn_d  = (state_d == IDLE);
        sdin_d = (state_d == IDLE) ? 1'b0 : shift_d[BYTE_W-1];
    end

    // State and output registers; synchronous active-low reset aborts any transfer.
    always_ff @(posedge clk_in) begin
        if (!resetn) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= 3'd0;
            div_cnt_q <= 8'd0;
            dc_q      <= DC_CMD;
            sclk_q    <= 1'b0;
            sdin_q    <= 1'b0;
            csn_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            dc_q      <= dc_d;
            sclk_q    <= sclk_d;
            sdin_q    <= sdin_d;
            csn_q     <= csn_d;
        end
    end

    assign oled_sclk = sclk_q;
    assign oled_sdin = sdin_q;
    assign oled_csn  = csn_q;
    assign oled_dc   = dc_q;

endmodule

// File: tb/tb_ssd1306_spi_shifter.sv
// Bench for ssd1306_spi_shifter: instance 0 at CLK_DIV=2, instance 1 at
// CLK_DIV=1. A serial monitor decodes each SPI bus back into {dc,byte} and
// compares against an expected queue filled at accept time.
module tb_ssd1306_spi_shifter;
  import ssd1306_pkg::*;

`ifdef SSD1306_SPI_BACK2BACK_EN
  localparam int B2B = 1;
`else
  localparam int B2B = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic [1:0] start, dcin, ready_w, busy_w, sclk_w, sdin_w, csn_w, dc_w;
  logic [7:0] din [2];

  ssd1306_spi_shifter #(.CLK_DIV(2)) dut0 (
    .clk_in(clk), .resetn(resetn), .byte_start(start[0]), .byte_in(din[0]),
    .dc_in(dcin[0]), .byte_ready(ready_w[0]), .busy(busy_w[0]),
    .oled_sclk(sclk_w[0]), .oled_sdin(sdin_w[0]), .oled_csn(csn_w[0]), .oled_dc(dc_w[0]));

  ssd1306_spi_shifter #(.CLK_DIV(1)) dut1 (
    .clk_in(clk), .resetn(resetn), .byte_start(start[1]), .byte_in(din[1]),
    .dc_in(dcin[1]), .byte_ready(ready_w[1]), .busy(busy_w[1]),
    .oled_sclk(sclk_w[1]), .oled_sdin(sdin_w[1]), .oled_csn(csn_w[1]), .oled_dc(dc_w[1]));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];
  bit mon_en = 1'b0;
  bit abort_ok = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / serial monitor ----------------
  logic [7:0] sh [2];
  int         bitn [2];
  int         last_rise [2];
  logic       prev_sclk [2];
  logic       prev_csn [2];

  task automatic match(input int d, input logic [8:0] got);
    logic [8:0] e;
    bit have;
    have = 1'b0;
    e = '0;
    if (d == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
    if (d == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
    if (!have) begin
      checks++;
      errors++;
      $display("FAIL unexpected_byte dut%0d: got 0x%0h expected none", d, got);
    end else begin
      check(d == 0 ? "capture_dut0" : "capture_dut1", 32'(got), 32'(e));
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mon_en) begin
        if (!csn_w[d] && sclk_w[d] && !prev_sclk[d]) begin
          if (bitn[d] > 0) check("sclk_period", 32'(cyc - last_rise[d]), (d == 0) ? 32'd4 : 32'd2);
          last_rise[d] = cyc;
          sh[d] = {sh[d][6:0], sdin_w[d]};
          bitn[d]++;
          if (bitn[d] == 8) begin
            match(d, {dc_w[d], sh[d]});
            bitn[d] = 0;
          end
        end
        if (csn_w[d] && !prev_csn[d]) begin
          if (bitn[d] != 0 && !abort_ok) check("partial_frame", 32'(bitn[d]), 32'd0);
          bitn[d] = 0;
        end
      end
      prev_sclk[d] = sclk_w[d];
      prev_csn[d]  = csn_w[d];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input int d, input logic [7:0] b, input logic dc);
    if (d == 0) exp_q0.push_back({dc, b});
    else        exp_q1.push_back({dc, b});
  endtask

  // Send one byte through instance d; returns cycles until ready and csn-low count.
  task automatic send(input int d, input logic [7:0] b, input logic dc,
                      output int lat, output int csn_low);
    @(negedge clk);
    check("ready_before_send", 32'(ready_w[d]), 32'd1);
    start[d] = 1'b1;
    din[d]   = b;
    dcin[d]  = dc;
    push_exp(d, b, dc);
    @(posedge clk);
    #1 start[d] = 1'b0;
    lat = 0;
    csn_low = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("csn_after_accept", 32'(csn_w[d]), 32'd0);
        check("sdin_msb", 32'(sdin_w[d]), 32'(b[7]));
        check("dc_latched", 32'(dc_w[d]), 32'(dc));
        check("busy_after_accept", 32'(busy_w[d]), 32'd1);
      end
      if (ready_w[d]) break;
      lat++;
      if (!csn_w[d]) csn_low++;
    end
  endtask

  task automatic wait_idle(input int d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (csn_w[d] && ready_w[d]) begin ok = 1'b1; break; end
    end
    check("idle_reached", 32'(ok), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         d;
    logic [7:0] b;
    logic       dc;
    int         div;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int lat, low, rises, csn_hi, pitch_exp;
    int acc [3];
    logic [7:0] sb [3];
    logic       sdc [3];
    int rem, rem_n;
    bit s, mready;
    logic [7:0] rb;
    logic rdc;
    logic prev;

    vecs[0] = '{0, 8'hAE, DC_CMD,  2};
    vecs[1] = '{0, 8'h3C, DC_DATA, 2};
    vecs[2] = '{0, 8'h00, DC_DATA, 2};
    vecs[3] = '{0, 8'hFF, DC_CMD,  2};
    vecs[4] = '{1, 8'h01, DC_CMD,  1};
    vecs[5] = '{1, 8'h80, DC_DATA, 1};
    vecs[6] = '{1, 8'h5A, DC_CMD,  1};

    // ---- reset ----
    start = '0; dcin = '0; din[0] = '0; din[1] = '0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready_w), 32'h3);
    check("rst_busy",  32'(busy_w),  32'h0);
    check("rst_csn",   32'(csn_w),   32'h3);
    check("rst_sclk",  32'(sclk_w),  32'h0);
    check("rst_sdin",  32'(sdin_w),  32'h0);
    check("rst_dc",    32'(dc_w),    32'h0);
    resetn = 1'b1;
    mon_en = 1'b1;

    // ---- table-driven single bytes ----
    for (int v = 0; v < 7; v++) begin
      send(vecs[v].d, vecs[v].b, vecs[v].dc, lat, low);
      check("ready_latency", 32'(lat), 32'(17 * vecs[v].div - B2B));
      check("csn_low_cycles", 32'(low), 32'(17 * vecs[v].div - B2B));
      wait_idle(vecs[v].d);
      check("dc_held_idle", 32'(dc_w[vecs[v].d]), 32'(vecs[v].dc));
    end

    // ---- busy ignore: 0xFF pulsed mid-transfer must vanish ----
    @(negedge clk);
    start[0] = 1'b1; din[0] = 8'hA5; dcin[0] = DC_DATA;
    push_exp(0, 8'hA5, DC_DATA);
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("busy_at_plus5", 32'(busy_w[0]), 32'd1);
    start[0] = 1'b1; din[0] = 8'hFF; dcin[0] = DC_CMD;
    @(posedge clk);
    #1 start[0] = 1'b0;
    wait_idle(0);
    low = 0;
    repeat (40) begin @(negedge clk); if (!csn_w[0]) low++; end
    check("no_second_transfer", 32'(low), 32'd0);
    check("dc_not_resampled", 32'(dc_w[0]), 32'(DC_DATA));

    // ---- streaming with byte_start held high ----
    sb[0] = 8'h8D; sdc[0] = DC_CMD;
    sb[1] = 8'h14; sdc[1] = DC_CMD;
    sb[2] = 8'hFF; sdc[2] = DC_DATA;
    csn_hi = 0;
    @(negedge clk);
    start[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 100 && !ready_w[0]; j++) begin
        if (i > 0 && csn_w[0]) csn_hi++;
        @(negedge clk);
      end
      if (i > 0 && csn_w[0]) csn_hi++;
      din[0] = sb[i]; dcin[0] = sdc[i];
      push_exp(0, sb[i], sdc[i]);
      acc[i] = cyc;
      @(posedge clk);
      @(negedge clk);
      if (i > 0) check("stream_dc_at_accept", 32'(dc_w[0]), 32'(sdc[i]));
    end
    start[0] = 1'b0;
    pitch_exp = (B2B != 0) ? 34 : 35;
    check("stream_pitch_1", 32'(acc[1] - acc[0]), 32'(pitch_exp));
    check("stream_pitch_2", 32'(acc[2] - acc[1]), 32'(pitch_exp));
    check("stream_csn_gap", 32'(csn_hi), (B2B != 0) ? 32'd0 : 32'd2);
    wait_idle(0);

    // ---- reset mid-transfer of 0xC8 ----
    @(negedge clk);
    start[0] = 1'b1; din[0] = 8'hC8; dcin[0] = DC_DATA;
    @(posedge clk);
    #1 start[0] = 1'b0;
    rises = 0;
    prev = 1'b0;
    for (int j = 0; j < 200 && rises < 3; j++) begin
      @(negedge clk);
      if (sclk_w[0] && !prev) rises++;
      prev = sclk_w[0];
    end
    check("rises_before_abort", 32'(rises), 32'd3);
    abort_ok = 1'b1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("abort_csn", 32'(csn_w[0]), 32'd1);
    check("abort_sclk", 32'(sclk_w[0]), 32'd0);
    check("abort_ready", 32'(ready_w[0]), 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    abort_ok = 1'b0;
    send(0, 8'h81, DC_CMD, lat, low);
    check("post_abort_latency", 32'(lat), 32'(34 - B2B));
    wait_idle(0);

    // ---- randomized traffic against a timing model ----
    rem = 0;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      s   = ($urandom_range(0, 3) == 0);
      rb  = 8'($urandom);
      rdc = 1'($urandom);
      start[0] = s; din[0] = rb; dcin[0] = rdc;
      mready = (B2B != 0) ? (rem <= 1) : (rem == 0);
      check("rand_ready", 32'(ready_w[0]), 32'(mready));
      if (s && mready) begin
        push_exp(0, rb, rdc);
        rem_n = 34;
      end else begin
        rem_n = (rem > 0) ? rem - 1 : 0;
      end
      @(posedge clk);
      rem = rem_n;
    end
    #1 start[0] = 1'b0;
    wait_idle(0);
    wait_idle(1);
    repeat (4) @(negedge clk);
    check("exp_q0_drained", 32'(exp_q0.size()), 32'd0);
    check("exp_q1_drained", 32'(exp_q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssd1306_spi_shifter.md
Name: ssd1306_spi_shifter

Overview:
- Byte serializer directly downstream of the SSD1306 init sequencer and the pixel/data path.
- Accepts one 8-bit command/data byte per handshake and shifts it MSB-first to the panel over 4-wire SPI, mode 0 (SCLK idles low; panel samples on the rising edge).
- Owns oled_sclk, oled_sdin, oled_csn and oled_dc during transfers.
- Reports byte_ready so the upstream can advance its ROM index or FIFO.

Parameters:
- CLK_DIV, 2: clk_in cycles per SCLK half-period. Legal range 1..255.

Ports:
- clk_in  input  1  system clock
- resetn  input  1  synchronous, active-low reset
- byte_start  input  1  request to send byte_in; sampled only when byte_ready=1
- byte_in  input  8  byte to send; latched on accept
- dc_in  input  1  D/C level for this byte (0 = command, 1 = data); latched on accept
- byte_ready  output  1  idle, can accept a byte this cycle
- busy  output  1  transfer in progress (the inverse of byte_ready)
- oled_sclk  output  1  SPI clock
- oled_sdin  output  1  SPI MOSI
- oled_csn  output  1  chip select, active low
- oled_dc  output  1  data/command select

Behaviour:
- Reset (resetn=0 at a clk_in edge):
  - state=IDLE, byte_ready=1, busy=0, oled_sclk=0, oled_sdin=0, oled_csn=1, oled_dc=0, counters=0.
  - Takes effect mid-transfer too: the transfer aborts immediately and no partial byte is resumed.
- States: IDLE, LOW, HIGH, HOLD.
- byte_ready is combinational: byte_ready = (state==IDLE), except as modified by the optional feature.
- Accept: byte_start && byte_ready at edge t. The byte is accepted at that edge.
  - At t: shift register <= byte_in; oled_dc <= dc_in; bit_cnt <= 7; div_cnt <= 0; state <= LOW.
  - From t+1: oled_csn=0 and oled_sdin=byte_in[7].
- LOW: oled_sclk=0. After CLK_DIV cycles, go to HIGH with div_cnt cleared.
- HIGH: oled_sclk=1. After CLK_DIV cycles:
  - If bit_cnt==0, go to HOLD.
  - Otherwise shift left, bit_cnt--, go to LOW.
  - oled_sdin changes only on the HIGH->LOW transition. SDIN is stable for the full SCLK high phase plus one half-period of setup.
- HOLD: oled_sclk=0, oled_csn=0 for CLK_DIV cycles, then IDLE. oled_csn=1 from the first IDLE cycle.
- oled_dc holds its latched value through IDLE until the next accept.
- Timing:
  - Exactly 8 rising SCLK edges per byte.
  - The non-IDLE period lasts 17*CLK_DIV cycles.
  - byte_ready returns high 17*CLK_DIV cycles after the accept edge (34 cycles at CLK_DIV=2).
- byte_start while busy is ignored. It is not queued, and the input byte is not sampled.
- byte_start held high continuously: a new byte is accepted on each IDLE cycle. This gives at least one IDLE cycle with csn=1 between bytes.
- div_cnt is 8 bits wide. It compares against CLK_DIV-1, so there is no wrap hazard.

Optional Feature:
- Macro: SSD1306_SPI_BACK2BACK_EN.
- Defined:
  - byte_ready is also asserted in the last HOLD cycle.
  - An accept there loads the next byte straight into LOW. oled_csn stays 0 and IDLE is skipped.
  - Byte pitch becomes 17*CLK_DIV cycles.
  - oled_dc updates to the new dc_in at the same edge.
- Undefined: the behaviour described above. csn always deasserts for at least one cycle between bytes, and the pitch is 17*CLK_DIV+1 cycles.

Decomposition:
- Package ssd1306_pkg holds:
  - the state enum (IDLE/LOW/HIGH/HOLD), shared with the init sequencer;
  - localparam DC_CMD=0 and DC_DATA=1;
  - the byte width constant 8.
- No sub-module. The divider and the bit counter are a few lines each and stay inline.

Test Plan:
- Reset: hold resetn=0 for 3 cycles -> byte_ready=1, busy=0, csn=1, sclk=0, sdin=0, dc=0.
- Single command byte, CLK_DIV=2: byte_in=0xAE, dc_in=0 -> 8 rising SCLK edges; sampled bits 1,0,1,0,1,1,1,0; dc=0; csn low for 34 cycles; byte_ready high 34 cycles after accept.
- Busy ignore: accept 0xA5, then pulse byte_start with 0xFF at cycle +5 -> serial capture is only 0xA5; no second transfer; csn=1 after completion.
- Streaming: hold byte_start=1 and feed 0x8D, 0x14 (dc=0), then 0xFF (dc=1) -> three bytes captured in order; dc changes only at accept edges. Without the macro: csn high for exactly 1 cycle between bytes, pitch 35 cycles. With the macro: csn continuously low, pitch 34 cycles.
- Reset mid-transfer: deassert resetn after the 3rd SCLK rise of 0xC8 -> next edge gives csn=1, sclk=0; a subsequent accept of 0x81 transmits a full, correct 0x81.
- CLK_DIV=1: byte 0x01 -> SCLK period 2 cycles; byte_ready returns 17 cycles after accept; only the last bit is sampled as 1.
